imm_decode_stage: RTL and testbench

Registered, parametrised immediate-decode pipeline stage for the RISC-V core. Accepts one 32-bit instruction per cycle over a valid/ready handshake and delivers the sign- or zero-extended immediate, a one-hot format code and an illegal-encoding flag one cycle later. A two-entry skid buffer keeps full throughput under backpressure. Supports XLEN of 32 or 64, including RV64 shift-amount rules.

---
 rtl/imm_decode_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_imm_decode_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered RISC-V immediate decoder with a two-entry
// skid buffer on a valid/ready handshake.
//
// Parameters: XLEN (32 or 64) sets the immediate width; TAG_W sets the width
// of the sideband tag that travels with each instruction.
//
// Optional feature macro: IMMGEN_CSR_UIMM_EN
//   defined   -> CSRRWI/CSRRSI/CSRRCI (SYSTEM, funct3[2]=1) return the 5-bit
//                zero-extended uimm from inst[19:15]
//   undefined -> every SYSTEM encoding returns sext(inst[31:20])
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [5:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // One-hot format codes, bit order {U,J,B,S,I,NONE}.
  localparam logic [5:0] FMT_NONE = 6'b000001;
  localparam logic [5:0] FMT_I    = 6'b000010;
  localparam logic [5:0] FMT_S    = 6'b000100;
  localparam logic [5:0] FMT_B    = 6'b001000;
  localparam logic [5:0] FMT_J    = 6'b010000;
  localparam logic [5:0] FMT_U    = 6'b100000;

  // RV64 enables 6-bit shamt on OP-IMM and the OP-IMM-32 opcode.
  localparam bit IS_RV64 = (XLEN == 64);

  // Stored entry: {imm, fmt, illegal, tag}.
  localparam int PW = XLEN + 6 + 1 + TAG_W;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;

  // ---------------------------------------------------------------------
  // Immediate field extraction (all candidates formed in parallel)
  // ---------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt5;
  logic [XLEN-1:0] shamt6;

  assign opcode   = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  // SLLI / SRLI / SRAI (and their -W forms) use funct3 001 and 101.
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                   in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_j  = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12],
                   in_inst[20], in_inst[30:21], 1'b0};
  assign shamt5 = {{(XLEN-5){1'b0}}, in_inst[24:20]};
  assign shamt6 = {{(XLEN-6){1'b0}}, in_inst[25:20]};

  // U-type only needs sign extension when XLEN is wider than the 32-bit field.
  generate
    if (XLEN > 32) begin : g_u_wide
      assign imm_u = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};
    end else begin : g_u_narrow
      assign imm_u = {in_inst[31:12], 12'b0};
    end
  endgenerate

`ifdef IMMGEN_CSR_UIMM_EN
  logic [XLEN-1:0] uimm;
  assign uimm = {{(XLEN-5){1'b0}}, in_inst[19:15]};
`endif

  // ---------------------------------------------------------------------
  // Opcode-driven selection of immediate, format and illegal flag
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] dec_imm;
  logic [5:0]      dec_fmt;
  logic            dec_illegal;

  // Decode the incoming instruction; unknown opcodes fall through to NONE.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b1;
    case (opcode)
      OP_LOAD, OP_JALR: begin
        dec_imm     = imm_i;
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
      end
      OP_SYSTEM: begin
        dec_imm     = imm_i;
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
`ifdef IMMGEN_CSR_UIMM_EN
        if (funct3[2]) begin
          dec_imm = uimm;
        end
`endif
      end
      OP_IMM: begin
        dec_fmt = FMT_I;
        if (is_shift) begin
          if (IS_RV64) begin
            dec_imm     = shamt6;
            dec_illegal = 1'b0;
          end else begin
            // shamt[5] is reserved on RV32.
            dec_imm     = shamt5;
            dec_illegal = in_inst[25];
          end
        end else begin
          dec_imm     = imm_i;
          dec_illegal = 1'b0;
        end
      end
      OP_IMM_32: begin
        if (IS_RV64) begin
          dec_fmt = FMT_I;
          if (is_shift) begin
            // Word shifts only have a 5-bit shamt.
            dec_imm     = shamt5;
            dec_illegal = in_inst[25];
          end else begin
            dec_imm     = imm_i;
            dec_illegal = 1'b0;
          end
        end
      end
      OP_STORE: begin
        dec_imm     = imm_s;
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
      end
      OP_BRANCH: begin
        dec_imm     = imm_b;
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
      end
      OP_JAL: begin
        dec_imm     = imm_j;
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
      end
      OP_LUI, OP_AUIPC: begin
        dec_imm     = imm_u;
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Two-entry skid buffer: M drives the outputs, S catches the entry that
  // arrives while M is stalled.
  // ---------------------------------------------------------------------
  logic [PW-1:0] dec_payload;
  logic [PW-1:0] m_payload_reg;
  logic [PW-1:0] m_payload_next;
  logic [PW-1:0] s_payload_reg;
  logic [PW-1:0] s_payload_next;
  logic          m_valid_reg;
  logic          m_valid_next;
  logic          s_valid_reg;
  logic          s_valid_next;
  logic          in_fire;
  logic          out_fire;

  assign dec_payload = {dec_imm, dec_fmt, dec_illegal, in_tag};

  // Ready depends only on registered occupancy plus rst/flush, never on
  // out_ready, so there is no combinational path through the stage.
  assign in_ready  = ~s_valid_reg & ~rst & ~flush;
  assign out_valid = m_valid_reg;
  assign {out_imm, out_fmt, out_illegal, out_tag} = m_payload_reg;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_reg & out_ready;

  // Next-state for the buffer; flush discards everything including any
  // same-cycle input.
  always_comb begin
    m_valid_next   = m_valid_reg;
    s_valid_next   = s_valid_reg;
    m_payload_next = m_payload_reg;
    s_payload_next = s_payload_reg;
    if (flush) begin
      m_valid_next = 1'b0;
      s_valid_next = 1'b0;
    end else if (in_fire && (!m_valid_reg || (out_fire && !s_valid_reg))) begin
      // M is free (or freeing) and nothing older is waiting in S.
      m_payload_next = dec_payload;
      m_valid_next   = 1'b1;
    end else if (in_fire) begin
      // M is stalled; in_ready guarantees S is empty here.
      s_payload_next = dec_payload;
      s_valid_next   = 1'b1;
    end else if (out_fire && s_valid_reg) begin
      m_payload_next = s_payload_reg;
      s_valid_next   = 1'b0;
    end else if (out_fire) begin
      m_valid_next = 1'b0;
    end
  end

  // Buffer state registers with synchronous reset clearing payload too.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_reg   <= 1'b0;
      s_valid_reg   <= 1'b0;
      m_payload_reg <= '0;
      s_payload_reg <= '0;
    end else begin
      m_valid_reg   <= m_valid_next;
      s_valid_reg   <= s_valid_next;
      m_payload_reg <= m_payload_next;
      s_payload_reg <= s_payload_next;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Testbench for imm_decode_stage: directed plan cases plus randomized
// traffic, checked by a scoreboard fed from a behavioural decode model.
module tb_imm_decode_stage;
  localparam int XLEN  = 32;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [5:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [5:0]       fmt;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sign-interpret a 'bits'-wide field value.
  function automatic longint sx(input longint val, input int bits);
    longint half;
    half = longint'(1) << (bits - 1);
    return (val >= half) ? val - 2 * half : val;
  endfunction

  // Reference decode: arithmetic on instruction fields; fmt index 0..5 = NONE,I,S,B,J,U.
  function automatic exp_t model(input logic [31:0] inst, input logic [TAG_W-1:0] tag);
    exp_t   e;
    longint v;
    int     kind;
    bit     ill;
    bit     shift;
    shift = (inst[14:12] == 3'd1) || (inst[14:12] == 3'd5);
    v = 0; kind = 1; ill = 1'b0;
    case (inst[6:0])
      7'h03, 7'h67: v = sx(longint'(inst[31:20]), 12);
      7'h73: begin
        v = sx(longint'(inst[31:20]), 12);
`ifdef IMMGEN_CSR_UIMM_EN
        if (inst[14:12] >= 3'd4) v = longint'(inst[19:15]);
`endif
      end
      7'h13: begin
        if (shift && XLEN == 64) v = longint'(inst[25:20]);
        else if (shift) begin v = longint'(inst[24:20]); ill = inst[25]; end
        else v = sx(longint'(inst[31:20]), 12);
      end
      7'h1B: begin
        if (XLEN != 64) begin kind = 0; ill = 1'b1; end
        else if (shift) begin v = longint'(inst[24:20]); ill = inst[25]; end
        else v = sx(longint'(inst[31:20]), 12);
      end
      7'h23: begin kind = 2; v = sx(longint'(inst[31:25]) * 32 + longint'(inst[11:7]), 12); end
      7'h63: begin
        kind = 3;
        v = sx(longint'(inst[31]) * 4096 + longint'(inst[7]) * 2048 +
               longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2, 13);
      end
      7'h6F: begin
        kind = 4;
        v = sx(longint'(inst[31]) * (longint'(1) << 20) + longint'(inst[19:12]) * 4096 +
               longint'(inst[20]) * 2048 + longint'(inst[30:21]) * 2, 21);
      end
      7'h37, 7'h17: begin kind = 5; v = sx(longint'(inst[31:12]) * 4096, 32); end
      default: begin kind = 0; ill = 1'b1; v = 0; end
    endcase
    e.imm = v[XLEN-1:0];
    e.fmt = 6'b000001 << kind;
    e.ill = ill;
    e.tag = tag;
    return e;
  endfunction

  // Monitor: compares the presented output with the scoreboard head each
  // cycle, pops on release, and checks payload stability while stalled.
  exp_t prev;
  bit   prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t cur;
    cur = '{imm: out_imm, fmt: out_fmt, ill: out_illegal, tag: out_tag};
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 128'(out_valid), 128'(0));
        end else begin
          check("out_payload", 128'(cur), 128'(sb[0]));
          if (out_ready) begin
            $display("[TB] out tag=0x%0h imm=0x%0h fmt=%b ill=%0b", out_tag, out_imm, out_fmt, out_illegal);
            void'(sb.pop_front());
          end
        end
        if (prev_stall) check("stall_stable", 128'(cur), 128'(prev));
      end else if (sb.size() != 0) begin
        check("out_valid_pending", 128'(out_valid), 128'(1));
      end
      prev_stall = out_valid && !out_ready;
      prev = cur;
    end
  end

  // One clock of stimulus: sample handshake mid-cycle, record the accept
  // (or flush) at the edge, return 1 time unit after the edge.
  task automatic step();
    bit acc;
    bit fl;
    @(negedge clk);
    acc = in_valid && in_ready;
    fl  = flush;
    @(posedge clk);
    if (fl) sb.delete();
    else if (acc) sb.push_back(model(in_inst, in_tag));
    #1;
  endtask

  logic [31:0] plan_inst [5] = '{32'hFFF00093, 32'hFFDFF0EF, 32'h12345037, 32'h02009093, 32'h3002D0F3};
  logic [31:0] plan_imm  [5];
  logic [5:0]  plan_fmt  [5] = '{6'b000010, 6'b010000, 6'b100000, 6'b000010, 6'b000010};
  logic        plan_ill  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [6:0]  ops [11] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h1B, 7'h33};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b0;
    plan_imm[0] = 32'hFFFFFFFF;
    plan_imm[1] = 32'hFFFFFFFC;
    plan_imm[2] = 32'h12345000;
    plan_imm[3] = 32'h00000000;
`ifdef IMMGEN_CSR_UIMM_EN
    plan_imm[4] = 32'h00000005;
`else
    plan_imm[4] = 32'h00000300;
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_imm", 128'(out_imm), 128'(0));
    check("rst_out_fmt", 128'(out_fmt), 128'(0));
    check("rst_out_illegal", 128'(out_illegal), 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 128'(in_ready), 128'(1));
    mon_en = 1'b1;

    // Directed decode cases, back to back, one-cycle latency.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_inst = plan_inst[i];
      in_tag  = TAG_W'(i + 100);
      step();
      check($sformatf("plan%0d_valid", i), 128'(out_valid), 128'(1));
      if (i != 3) check($sformatf("plan%0d_imm", i), 128'(out_imm), 128'(plan_imm[i]));
      check($sformatf("plan%0d_fmt", i), 128'(out_fmt), 128'(plan_fmt[i]));
      check($sformatf("plan%0d_illegal", i), 128'(out_illegal), 128'(plan_ill[i]));
    end
    in_valid = 1'b0;
    step(); step();

    // Backpressure: tags 1 and 2 fill the buffer, 3 stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093;
    in_tag = 1; step();
    in_tag = 2; step();
    check("bp_in_ready_full", 128'(in_ready), 128'(0));
    in_tag = 3; step(); step();
    check("bp_in_ready_stall", 128'(in_ready), 128'(0));
    check("bp_head_tag", 128'(out_tag), 128'(1));
    out_ready = 1'b1;
    step();
    check("bp_out2_valid", 128'(out_valid), 128'(1));
    check("bp_out2_tag", 128'(out_tag), 128'(2));
    step();
    check("bp_out3_valid", 128'(out_valid), 128'(1));
    check("bp_out3_tag", 128'(out_tag), 128'(3));
    in_valid = 1'b0;
    step();
    check("bp_drained", 128'(out_valid), 128'(0));

    // Flush with both entries full and an input pending.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag = 32'h10; step();
    in_tag = 32'h11; step();
    in_tag = 32'h12;
    flush  = 1'b1;
    #1;
    check("flush_in_ready", 128'(in_ready), 128'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready_after", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_no_ghost", 128'(out_valid), 128'(0));

    // Reset while entries are held.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag = 32'h20; in_inst = 32'h80000037; step();
    in_tag = 32'h21; step();
    in_tag = 32'h22;
    mon_en = 1'b0;
    rst = 1'b1;
    sb.delete();
    #1;
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    step();
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_outputs_zero", 128'({out_imm, out_fmt, out_illegal, out_tag}), 128'(0));
    check("midrst_in_ready_hold", 128'(in_ready), 128'(0));
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("midrst_in_ready_after", 128'(in_ready), 128'(1));
    check("midrst_out_valid_after", 128'(out_valid), 128'(0));
    mon_en = 1'b1;

    // Randomized traffic with random backpressure and occasional flush.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      int pick;
      r = $urandom;
      pick = int'($urandom_range(0, 11));
      if (pick < 11) r[6:0] = ops[pick];
      in_inst   = r;
      in_tag    = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      check("rand_in_ready", 128'(in_ready), 128'((sb.size() < 2) && !flush));
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    check("final_drain", 128'(sb.size()), 128'(0));
    step();
    check("final_out_valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
